// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed read ports, a hardwired zero register, an
// auto-incrementing PC register, condition flags and a per-register busy scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int PC_REG = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_a_num,
    output logic [DATA_W-1:0] rd_a_data,
    output logic              rd_a_busy,
    input  logic [ADDR_W-1:0] rd_b_num,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_b_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flags_en,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_out,
    output logic [2:0]        cond_out,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_num,
    output logic              lock_err,
    output logic              any_busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q, lock_d;
    logic [2:0]          cond_q, cond_d;
    logic                lock_err_q, lock_err_d;

    logic wr_valid;
    logic wr_hits_a, wr_hits_b, wr_hits_lock;

    assign wr_valid     = wr_en && (wr_num != '0);
    assign wr_hits_a    = wr_en && (wr_num == rd_a_num);
    assign wr_hits_b    = wr_en && (wr_num == rd_b_num);
    assign wr_hits_lock = wr_en && (wr_num == lock_num);

    // Register 0 reads as zero regardless of storage; lock bit 0 is never set.
    always_comb begin
        rd_a_data = '0;
        if (rd_a_num != '0) begin
            rd_a_data = wr_hits_a ? wr_data : regs_q[rd_a_num];
        end
    end

    always_comb begin
        rd_b_data = '0;
        if (rd_b_num != '0) begin
            rd_b_data = wr_hits_b ? wr_data : regs_q[rd_b_num];
        end
    end

    // A write landing this cycle satisfies the pending dependency.
    assign rd_a_busy = lock_q[rd_a_num] && !wr_hits_a;
    assign rd_b_busy = lock_q[rd_b_num] && !wr_hits_b;

    assign pc_out   = regs_q[PC_IDX];
    assign cond_out = cond_q;
    assign lock_err = lock_err_q;
    assign any_busy = |lock_q;

    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves it unassigned (no latches).
        regs_d     = regs_q;
        lock_d     = lock_q;
        cond_d     = cond_q;
        lock_err_d = 1'b0;

        if (pc_inc) begin
            regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(1);
        end

        // Ordered after the increment so a same-cycle write to the PC wins.
        if (wr_valid) begin
            regs_d[wr_num] = wr_data;
            lock_d[wr_num] = 1'b0;
        end

        if (wr_en && flags_en) begin
            cond_d = {wr_data == '0,
                      !wr_data[DATA_W-1] && (wr_data != '0),
                      wr_data[DATA_W-1]};
        end

        // Re-reservation is ordered after the write so it wins over the clear.
        if (lock_en && (lock_num != '0)) begin
            if (lock_q[lock_num] && !wr_hits_lock) begin
                lock_err_d = 1'b1;
            end
            lock_d[lock_num] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register array is reset too, since reset must leave every register reading 0.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            lock_q     <= '0;
            cond_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge value.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            lock_q     <= lock_d;
            cond_q     <= cond_d;
            lock_err_q <= lock_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: expectations are queued when stimulus
// is applied and compared against the DUT outputs once they settle.
module tb_regfile_scoreboard;

    localparam int DW = 16;
    localparam int AW = 3;

    localparam int S_A_DATA = 0;
    localparam int S_A_BUSY = 1;
    localparam int S_B_DATA = 2;
    localparam int S_B_BUSY = 3;
    localparam int S_PC     = 4;
    localparam int S_COND   = 5;
    localparam int S_ERR    = 6;
    localparam int S_ANY    = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_a_num, rd_b_num, wr_num, lock_num;
    logic [DW-1:0] rd_a_data, rd_b_data, wr_data, pc_out;
    logic          rd_a_busy, rd_b_busy, wr_en, flags_en, pc_inc, lock_en;
    logic [2:0]    cond_out;
    logic          lock_err, any_busy;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .PC_REG(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_num  (rd_a_num),
        .rd_a_data (rd_a_data),
        .rd_a_busy (rd_a_busy),
        .rd_b_num  (rd_b_num),
        .rd_b_data (rd_b_data),
        .rd_b_busy (rd_b_busy),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .flags_en  (flags_en),
        .pc_inc    (pc_inc),
        .pc_out    (pc_out),
        .cond_out  (cond_out),
        .lock_en   (lock_en),
        .lock_num  (lock_num),
        .lock_err  (lock_err),
        .any_busy  (any_busy)
    );

    typedef struct {
        string         tag;
        int            sig;
        logic [DW-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] observe(input int sig);
        case (sig)
            S_A_DATA: return rd_a_data;
            S_A_BUSY: return DW'(rd_a_busy);
            S_B_DATA: return rd_b_data;
            S_B_BUSY: return DW'(rd_b_busy);
            S_PC:     return pc_out;
            S_COND:   return DW'(cond_out);
            S_ERR:    return DW'(lock_err);
            S_ANY:    return DW'(any_busy);
            default:  return 'x;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sig, input logic [DW-1:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        flags_en = 1'b0;
        pc_inc   = 1'b0;
        lock_en  = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] num, input logic [DW-1:0] data, input logic fl);
        wr_en    = 1'b1;
        wr_num   = num;
        wr_data  = data;
        flags_en = fl;
    endtask

    task automatic lock(input logic [AW-1:0] num);
        lock_en  = 1'b1;
        lock_num = num;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_a_num = 3'd3;
        rd_b_num = 3'd5;
        wr_num   = '0;
        wr_data  = '0;
        lock_num = '0;
        idle();
        #1;

        expect_out("rst_a_data", S_A_DATA, 16'h0000);
        expect_out("rst_b_data", S_B_DATA, 16'h0000);
        expect_out("rst_a_busy", S_A_BUSY, 16'h0000);
        expect_out("rst_cond",   S_COND,   16'h0000);
        expect_out("rst_pc",     S_PC,     16'h0000);
        expect_out("rst_any",    S_ANY,    16'h0000);
        expect_out("rst_err",    S_ERR,    16'h0000);
        settle();

        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Write r3 with bypass, then stored; both ports on r3.
        rd_a_num = 3'd3;
        rd_b_num = 3'd3;
        write(3'd3, 16'h1234, 1'b0);
        expect_out("r3_bypass_a", S_A_DATA, 16'h1234);
        expect_out("r3_bypass_b", S_B_DATA, 16'h1234);
        settle();
        step();
        idle();
        expect_out("r3_stored_a", S_A_DATA, 16'h1234);
        expect_out("r3_stored_b", S_B_DATA, 16'h1234);
        settle();

        // Register 0 discards writes but still updates flags.
        rd_a_num = 3'd0;
        write(3'd0, 16'hFFFF, 1'b1);
        expect_out("r0_bypass", S_A_DATA, 16'h0000);
        settle();
        step();
        idle();
        expect_out("r0_stored", S_A_DATA, 16'h0000);
        expect_out("cond_neg",  S_COND,   16'h0001);
        settle();

        rd_a_num = 3'd2;
        write(3'd2, 16'h0000, 1'b1);
        step();
        write(3'd2, 16'h0005, 1'b0);
        expect_out("cond_zero", S_COND, 16'h0004);
        settle();
        step();
        idle();
        expect_out("cond_hold", S_COND,   16'h0004);
        expect_out("r2_value",  S_A_DATA, 16'h0005);
        settle();
        write(3'd2, 16'h7FFF, 1'b1);
        step();
        idle();
        expect_out("cond_pos", S_COND, 16'h0002);
        settle();

        // PC wrap, write-wins-over-increment, no bypass on pc_out.
        write(3'd6, 16'hFFFF, 1'b0);
        expect_out("pc_no_bypass", S_PC, 16'h0000);
        settle();
        step();
        idle();
        expect_out("pc_loaded", S_PC, 16'hFFFF);
        settle();
        pc_inc = 1'b1;
        step();
        expect_out("pc_wrap", S_PC, 16'h0000);
        settle();
        write(3'd6, 16'h0040, 1'b0);
        step();
        idle();
        expect_out("pc_write_wins", S_PC, 16'h0040);
        settle();
        pc_inc = 1'b1;
        step();
        idle();
        expect_out("pc_inc", S_PC, 16'h0041);
        settle();

        // Lock r4, then the write releases it.
        rd_a_num = 3'd4;
        lock(3'd4);
        step();
        idle();
        expect_out("lock_busy", S_A_BUSY, 16'h0001);
        expect_out("lock_any",  S_ANY,    16'h0001);
        expect_out("lock_noerr", S_ERR,   16'h0000);
        settle();
        write(3'd4, 16'h00AA, 1'b0);
        expect_out("wr_busy_drop", S_A_BUSY, 16'h0000);
        expect_out("wr_r4_bypass", S_A_DATA, 16'h00AA);
        settle();
        step();
        idle();
        expect_out("r4_unlocked", S_A_BUSY, 16'h0000);
        expect_out("any_clear",   S_ANY,    16'h0000);
        settle();

        // Double reservation: one-cycle error pulse.
        lock(3'd4);
        step();
        lock(3'd4);
        step();
        idle();
        expect_out("dbl_err",  S_ERR,    16'h0001);
        expect_out("dbl_busy", S_A_BUSY, 16'h0001);
        settle();
        step();
        expect_out("err_pulse_end", S_ERR,    16'h0000);
        expect_out("still_busy",    S_A_BUSY, 16'h0001);
        settle();

        // Lock and write of a busy register in the same cycle.
        write(3'd4, 16'h5555, 1'b0);
        lock(3'd4);
        step();
        idle();
        expect_out("relock_data", S_A_DATA, 16'h5555);
        expect_out("relock_busy", S_A_BUSY, 16'h0001);
        expect_out("relock_err",  S_ERR,    16'h0000);
        settle();

        // lock_num = 0 is ignored.
        rd_b_num = 3'd0;
        lock(3'd0);
        step();
        idle();
        expect_out("lock0_err",  S_ERR,    16'h0000);
        expect_out("lock0_busy", S_B_BUSY, 16'h0000);
        settle();

        // Asynchronous reset mid-reservation.
        rd_a_num = 3'd1;
        rd_b_num = 3'd6;
        write(3'd1, 16'h7777, 1'b0);
        step();
        idle();
        lock(3'd1);
        step();
        idle();
        expect_out("pre_rst_busy", S_A_BUSY, 16'h0001);
        expect_out("pre_rst_data", S_A_DATA, 16'h7777);
        settle();
        rst_n = 1'b0;
        expect_out("arst_a_data", S_A_DATA, 16'h0000);
        expect_out("arst_a_busy", S_A_BUSY, 16'h0000);
        expect_out("arst_pc",     S_B_DATA, 16'h0000);
        expect_out("arst_pc_out", S_PC,     16'h0000);
        expect_out("arst_cond",   S_COND,   16'h0000);
        expect_out("arst_any",    S_ANY,    16'h0000);
        expect_out("arst_err",    S_ERR,    16'h0000);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
